// File: rtl/seq_divider16_if.sv
// Handshake and operand/result bundle for seq_divider16.
// The master drives requests; the divider sits on the slave side.
interface seq_divider16_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider16.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER16_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    seq_divider16_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r, r_r, d_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_r, rem_r;
    logic             dz_r;

    logic             accept, last, div_zero;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   sh;
    logic             no_borrow;
    logic [WIDTH-1:0] q_step, r_step;
    logic [WIDTH-1:0] quo_fin, rem_fin;

    assign accept   = (state == IDLE) && bus.start;
    assign last     = (state == RUN) && (cnt == CW'(1));
    assign div_zero = (bus.divisor == '0);

`ifdef SEQ_DIVIDER16_SIGNED_EN
    logic neg_q, neg_r;

    // Core always sees magnitudes; signs are reapplied on the final step.
    assign dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    assign dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
    assign quo_fin = neg_q ? (~q_step + 1'b1) : q_step;
    assign rem_fin = neg_r ? (~r_step + 1'b1) : r_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r <= bus.dividend[WIDTH-1];
        end
    end
`else
    assign dvd_mag = bus.dividend;
    assign dvs_mag = bus.divisor;
    assign quo_fin = q_step;
    assign rem_fin = r_step;
`endif

    // Partial remainder carries one extra bit so divisors above 2^(WIDTH-1) work.
    always_comb begin
        sh        = {r_r, q_r[WIDTH-1]};
        no_borrow = (sh >= {1'b0, d_r});
        r_step    = no_borrow ? WIDTH'(sh - {1'b0, d_r}) : sh[WIDTH-1:0];
        q_step    = {q_r[WIDTH-2:0], no_borrow};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = div_zero ? FINISH : RUN;
            RUN:     if (last)      state_nxt = FINISH;
            FINISH:                 state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= '0;
            r_r   <= '0;
            d_r   <= '0;
            cnt   <= '0;
            quo_r <= '0;
            rem_r <= '0;
            dz_r  <= 1'b0;
        end else if (accept) begin
            q_r <= dvd_mag;
            r_r <= '0;
            d_r <= dvs_mag;
            cnt <= CW'(WIDTH);
            if (div_zero) begin
                quo_r <= '1;
                rem_r <= bus.dividend;
                dz_r  <= 1'b1;
            end
        end else if (state == RUN) begin
            q_r <= q_step;
            r_r <= r_step;
            cnt <= cnt - 1'b1;
            if (last) begin
                quo_r <= quo_fin;
                rem_r <= rem_fin;
                dz_r  <= 1'b0;
            end
        end
    end

    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_seq_divider16.sv
// Randomized and directed checks of seq_divider16 against an arithmetic reference.
module tb_seq_divider16;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;

    seq_divider16_if #(.WIDTH(WIDTH)) bus ();

    seq_divider16 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.done) done_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Plain-arithmetic reference: integer division truncates toward zero.
    task automatic ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                           output logic dz);
        int sa, sb;
        dz = (b == 0);
        if (dz) begin
            q = '1;
            r = a;
        end else begin
`ifdef SEQ_DIVIDER16_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            q = WIDTH'(sa / sb);
            r = WIDTH'(sa % sb);
        end
    endtask

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = WIDTH'($urandom);
        bus.divisor  = WIDTH'($urandom);
    endtask

    // Called #1 after the accepting edge; counts edges until done and busy samples seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 200) begin
            if (bus.busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.done) begin
            total++;
            bad++;
            $display("FAIL timeout waiting for done");
        end
    endtask

    task automatic do_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] eq, er;
        logic             edz;
        int               lat, bcnt;
        ref_div(a, b, eq, er, edz);
        launch(a, b);
        wait_done(lat, bcnt);
        chk({tag, ".q"}, 32'(bus.quotient), 32'(eq));
        chk({tag, ".r"}, 32'(bus.remainder), 32'(er));
        chk({tag, ".dz"}, 32'(bus.div_by_zero), 32'(edz));
        chk({tag, ".lat"}, lat, edz ? 0 : WIDTH);
        chk({tag, ".busy"}, bcnt, edz ? 0 : WIDTH);
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, 32'(bus.done), 32'd0);
        chk({tag, ".held"}, 32'({bus.quotient, bus.remainder}), 32'({eq, er}));
    endtask

    initial begin
        logic [WIDTH-1:0] a, b;
        int lat, bcnt, d0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.done", 32'(bus.done), 0);
        chk("rst.q", 32'(bus.quotient), 0);
        chk("rst.r", 32'(bus.remainder), 0);
        chk("rst.dz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;

        do_div("d100_7", 16'd100, 16'd7);
        do_div("dffff_1", 16'hFFFF, 16'd1);
        do_div("d3_10", 16'd3, 16'd10);
        do_div("dz1234", 16'h1234, 16'd0);
        do_div("d9_3", 16'd9, 16'd3);
        do_div("dbigdiv", 16'hFFFE, 16'hFFFF);

        // Start pulsed mid-division must be dropped, not queued.
        d0 = done_seen;
        launch(16'd100, 16'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bcnt);
        chk("ign.q", 32'(bus.quotient), 14);
        chk("ign.r", 32'(bus.remainder), 2);
        repeat (25) @(posedge clk);
        #1;
        chk("ign.ndone", done_seen - d0, 1);

        // Reset mid-division abandons the operation with no done pulse.
        d0 = done_seen;
        launch(16'd1000, 16'd3);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst.busy", 32'(bus.busy), 0);
        chk("mrst.done", 32'(bus.done), 0);
        chk("mrst.out", 32'({bus.quotient, bus.remainder}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("mrst.ndone", done_seen - d0, 0);
        do_div("d1000_3", 16'd1000, 16'd3);

`ifdef SEQ_DIVIDER16_SIGNED_EN
        do_div("s-7_2", 16'hFFF9, 16'd2);
        do_div("sovf", 16'h8000, 16'hFFFF);
        do_div("s7_-2", 16'd7, 16'hFFFE);
        do_div("s-9_-4", 16'hFFF7, 16'hFFFC);
`endif

        for (int i = 0; i < 40; i++) begin
            a = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = WIDTH'($urandom_range(1, 15));
                default: b = WIDTH'($urandom);
            endcase
            do_div($sformatf("rnd%0d", i), a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
